// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmitter arbiter slice.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W   = 8;
  localparam int THRESH_W = 6;
  localparam int BAUD_W   = 2;

  localparam logic [THRESH_W-1:0] RST_THRESHOLD = 6'd48;
  localparam logic [BAUD_W-1:0]   RST_BAUD      = 2'd0;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the configuration handshake.
// The master side is the requester/host, the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_tx_arbiter_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cfg_valid;
  logic [THRESH_W-1:0]       cfg_threshold;
  logic [BAUD_W-1:0]         cfg_baudrate;
  logic                      cfg_ready;

  modport master (
    output req_valid, req_data, req_last, cfg_valid, cfg_threshold, cfg_baudrate,
    input  req_ready, cfg_ready
  );

  modport slave (
    input  req_valid, req_data, req_last, cfg_valid, cfg_threshold, cfg_baudrate,
    output req_ready, cfg_ready
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick. Returns the first set request
// at or after ptr (wrapping), as a one-hot vector, plus a found flag.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               found
);

  logic [NUM_REQ-1:0] rot_req_s;
  logic [NUM_REQ-1:0] rot_pick_s;
  logic               seen_s;

  // Rotate so ptr sits at bit 0, take the lowest hit, rotate the hit back
  always_comb begin
    rot_req_s  = {NUM_REQ{1'b0}};
    rot_pick_s = {NUM_REQ{1'b0}};
    pick       = {NUM_REQ{1'b0}};
    seen_s     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int p = 0; p < NUM_REQ; p++) begin
        rot_req_s[k] = rot_req_s[k] | (req[(p + k) % NUM_REQ] & (ptr == PTR_W'(p)));
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      rot_pick_s[k] = rot_req_s[k] & ~seen_s;
      seen_s        = seen_s | rot_req_s[k];
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int p = 0; p < NUM_REQ; p++) begin
        pick[(p + k) % NUM_REQ] = pick[(p + k) % NUM_REQ] | (rot_pick_s[k] & (ptr == PTR_W'(p)));
      end
    end
    found = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter,
// owning its threshold/baud config. Stall release on a silent owner: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int                  NUM_REQ           = 4,
  parameter logic [THRESH_W-1:0] DEFAULT_THRESHOLD = RST_THRESHOLD,
  parameter logic [BAUD_W-1:0]   DEFAULT_BAUD      = RST_BAUD,
  parameter int                  TIMEOUT_CYCLES    = 1024
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_arbiter_if.slave    req_if,
  input  logic                tx_buffer_full,
  output logic                tx_write_enable,
  output logic [BYTE_W-1:0]   tx_data,
  output logic [THRESH_W-1:0] tx_buffer_full_threshold,
  output logic [BAUD_W-1:0]   tx_baudrate_select,
  output logic [NUM_REQ-1:0]  grant,
  output logic                busy,
  output logic                timeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic [THRESH_W-1:0] thr_q, thr_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic                timeout_q, timeout_d;

  logic [NUM_REQ-1:0]  pick_s;
  logic                found_s;
  logic [PTR_W-1:0]    pick_idx_s;
  logic [PTR_W-1:0]    next_ptr_s;
  logic [NUM_REQ-1:0]  ready_s;
  logic                cfg_ready_s;
  logic [BYTE_W-1:0]   beat_data_s;
  logic                beat_s;
  logic                beat_last_s;
  logic                stall_hit_s;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req   (req_if.req_valid),
    .ptr   (ptr_q),
    .pick  (pick_s),
    .found (found_s)
  );

  // Handshake outputs and the granted requester's view of the byte bus
  always_comb begin
    if (reset && (state_q == SEND) && !tx_buffer_full) begin
      ready_s = grant_q;
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
    if (reset && (state_q == IDLE)) begin
      cfg_ready_s = 1'b1;
    end else begin
      cfg_ready_s = 1'b0;
    end
    beat_data_s = {BYTE_W{1'b0}};
    pick_idx_s  = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_data_s = beat_data_s | (req_if.req_data[i*BYTE_W +: BYTE_W] & {BYTE_W{grant_q[i]}});
      pick_idx_s  = pick_idx_s | (PTR_W'(i) & {PTR_W{pick_s[i]}});
    end
    beat_s      = |(req_if.req_valid & ready_s);
    beat_last_s = |(req_if.req_last & grant_q);
    next_ptr_s  = (owner_q == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : owner_q + PTR_W'(1);
  end

  assign req_if.req_ready = ready_s;
  assign req_if.cfg_ready = cfg_ready_s;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic             owner_valid_s;

  // Count cycles the owner is silent; cycles held off by a full buffer do not count
  always_comb begin
    owner_valid_s = |(req_if.req_valid & grant_q);
    stall_hit_s   = 1'b0;
    if ((state_q != SEND) || beat_s) begin
      stall_d = {CNT_W{1'b0}};
    end else if (!owner_valid_s) begin
      stall_d     = stall_q + CNT_W'(1);
      stall_hit_s = (stall_d == CNT_W'(TIMEOUT_CYCLES));
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= {CNT_W{1'b0}};
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign stall_hit_s = 1'b0;

  // The stall limit only matters when the release feature is built in
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Next-state: config wins over arbitration in IDLE; owner keeps the port until its last byte
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    we_d      = 1'b0;
    data_d    = data_q;
    thr_d     = thr_q;
    baud_d    = baud_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_if.cfg_valid) begin
          thr_d  = req_if.cfg_threshold;
          baud_d = req_if.cfg_baudrate;
        end else if (found_s) begin
          state_d = SEND;
          grant_d = pick_s;
          owner_d = pick_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (beat_s) begin
          we_d   = 1'b1;
          data_d = beat_data_s;
          if (beat_last_s) begin
            state_d = IDLE;
            grant_d = {NUM_REQ{1'b0}};
            ptr_d   = next_ptr_s;
          end else begin
            state_d = SEND;
          end
        end else if (stall_hit_s) begin
          state_d   = IDLE;
          grant_d   = {NUM_REQ{1'b0}};
          ptr_d     = next_ptr_s;
          timeout_d = 1'b1;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // State and registered transmitter-facing outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= {NUM_REQ{1'b0}};
      owner_q   <= {PTR_W{1'b0}};
      ptr_q     <= {PTR_W{1'b0}};
      we_q      <= 1'b0;
      data_q    <= {BYTE_W{1'b0}};
      thr_q     <= DEFAULT_THRESHOLD;
      baud_q    <= DEFAULT_BAUD;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      data_q    <= data_d;
      thr_q     <= thr_d;
      baud_q    <= baud_d;
      timeout_q <= timeout_d;
    end
  end

  assign tx_write_enable          = we_q;
  assign tx_data                  = data_q;
  assign tx_buffer_full_threshold = thr_q;
  assign tx_baudrate_select       = baud_q;
  assign grant                    = grant_q;
  assign busy                     = (state_q == SEND);
  assign timeout                  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: per-requester packet queues,
// a round-robin packet-level reference model, and a negedge monitor.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_buffer_full;
  logic       tx_write_enable;
  logic [7:0] tx_data;
  logic [5:0] tx_buffer_full_threshold;
  logic [1:0] tx_baudrate_select;
  logic [N-1:0] grant;
  logic       busy;
  logic       timeout;

  uart_tx_arbiter_if #(.NUM_REQ(N)) rif ();

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .req_if                   (rif),
    .tx_buffer_full           (tx_buffer_full),
    .tx_write_enable          (tx_write_enable),
    .tx_data                  (tx_data),
    .tx_buffer_full_threshold (tx_buffer_full_threshold),
    .tx_baudrate_select       (tx_baudrate_select),
    .grant                    (grant),
    .busy                     (busy),
    .timeout                  (timeout)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Stimulus streams (driver side) and expected bytes (scoreboard side): {last, data}
  logic [8:0] stream [N][$];
  int         sidx   [N];
  logic [8:0] m_q    [N][$];

  // Reference model state
  bit         mon_en = 1'b0;
  int         m_owner;
  int         m_ptr;
  bit         exp_we;
  logic [7:0] exp_data;
  logic [5:0] exp_thr;
  logic [1:0] exp_baud;
  int         wr_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (((v >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  // Monitor: pop expected bytes on writes, check arbitration/handshake outputs
  always @(negedge clock) begin
    if (mon_en) begin
      logic [8:0]   e;
      logic [N-1:0] eg;
      if (exp_we) begin
        chk("tx_write_enable", tx_write_enable, 1);
        if (m_owner < 0 || m_q[m_owner].size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_empty: write expected but no byte queued at %0t", $time);
        end else begin
          e = m_q[m_owner].pop_front();
          exp_data = e[7:0];
          wr_count++;
          if (e[8]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
          end
        end
      end else begin
        chk("tx_write_enable", tx_write_enable, 0);
      end
      chk("tx_data", tx_data, exp_data);
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      chk("grant", grant, eg);
      chk("busy", busy, m_owner >= 0);
      chk("cfg_ready", rif.cfg_ready, m_owner < 0);
      chk("req_ready", rif.req_ready, tx_buffer_full ? '0 : eg);
      chk("threshold", tx_buffer_full_threshold, exp_thr);
      chk("baudrate", tx_baudrate_select, exp_baud);
      chk("timeout", timeout, 0);
      exp_we = 1'b0;
      if (m_owner < 0) begin
        if (rif.cfg_valid) begin
          exp_thr  = rif.cfg_threshold;
          exp_baud = rif.cfg_baudrate;
        end else begin
          m_owner = model_pick(rif.req_valid, m_ptr);
        end
      end else begin
        exp_we = (((rif.req_valid >> m_owner) & 1) != 0) && !tx_buffer_full;
      end
    end
  end

  task automatic push_byte(input int i, input logic [7:0] d, input bit last);
    stream[i].push_back({last, d});
    m_q[i].push_back({last, d});
  endtask

  task automatic load_random(input int npkts, input int maxlen);
    for (int n = 0; n < npkts; n++) begin
      int i, len;
      i   = $urandom_range(N - 1);
      len = $urandom_range(maxlen, 1);
      for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
    end
  endtask

  task automatic drive_cycle(input int vpct, input int fpct, input int cpct);
    logic [N-1:0] acc;
    @(negedge clock);
    acc = rif.req_valid & rif.req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) sidx[i]++;
      if (sidx[i] < stream[i].size()) begin
        rif.req_valid[i]       = ($urandom_range(99) < vpct);
        rif.req_data[i*8 +: 8] = stream[i][sidx[i]][7:0];
        rif.req_last[i]        = stream[i][sidx[i]][8];
      end else begin
        rif.req_valid[i] = 1'b0;
        rif.req_last[i]  = 1'b0;
      end
    end
    tx_buffer_full    = ($urandom_range(99) < fpct);
    rif.cfg_valid     = ($urandom_range(99) < cpct);
    rif.cfg_threshold = 6'($urandom);
    rif.cfg_baudrate  = 2'($urandom);
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) begin
      if (sidx[i] < stream[i].size() || m_q[i].size() != 0) return 1'b0;
    end
    return (m_owner < 0) && !exp_we;
  endfunction

  task automatic run_phase(input string nm, input int vpct, input int fpct, input int cpct);
    int cyc = 0;
    while (!all_done() && cyc < 3000) begin
      drive_cycle(vpct, fpct, cpct);
      cyc++;
    end
    if (!all_done()) begin
      total++; bad++;
      $display("FAIL %s_budget: phase not drained after %0d cycles", nm, cyc);
    end
    repeat (2) drive_cycle(0, 0, 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", tx_write_enable, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_threshold", tx_buffer_full_threshold, 6'd48);
    chk("rst_baud", tx_baudrate_select, 2'd0);
    chk("rst_timeout", timeout, 0);
    chk("rst_req_ready", rif.req_ready, 0);
    chk("rst_cfg_ready", rif.cfg_ready, 0);
    rif.req_valid = '0; rif.req_data = '0; rif.req_last = '0;
    rif.cfg_valid = 1'b0; rif.cfg_threshold = '0; rif.cfg_baudrate = '0;
    tx_buffer_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      stream[i].delete(); m_q[i].delete(); sidx[i] = 0;
    end
    m_owner = -1; m_ptr = 0; exp_we = 1'b0; exp_data = 8'h00;
    exp_thr = 6'd48; exp_baud = 2'd0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int w0, cyc;
    do_reset();

    push_byte(1, 8'hA1, 1'b0);
    push_byte(1, 8'hA2, 1'b0);
    push_byte(1, 8'hA3, 1'b1);
    run_phase("single", 100, 0, 0);

    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) begin
        push_byte(i, 8'($urandom), 1'b0);
        push_byte(i, 8'($urandom), 1'b1);
      end
    run_phase("all_valid", 100, 0, 0);

    load_random(12, 6);
    run_phase("buffer_full", 80, 40, 0);

    load_random(12, 4);
    run_phase("config", 90, 20, 30);

    for (int b = 0; b < 4; b++) push_byte(2, 8'h50 + 8'(b), b == 3);
    w0 = wr_count; cyc = 0;
    while (wr_count < w0 + 2 && cyc < 40) begin
      drive_cycle(100, 0, 0);
      cyc++;
    end
    chk("midpkt_two_written", wr_count - w0, 2);
    do_reset();
    for (int i = 0; i < N; i++) begin
      push_byte(i, 8'h60 + 8'(i), 1'b0);
      push_byte(i, 8'h70 + 8'(i), 1'b1);
    end
    run_phase("after_reset", 100, 0, 0);

    repeat (3) begin
      load_random(10, 5);
      run_phase("mixed", 70, 25, 15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte-stream requesters. Arbitration is round-robin at packet granularity: a granted requester keeps the transmitter until its last byte is accepted. Writes are gated by the transmitter's buffer_full. The block also owns the transmitter configuration (threshold, baudrate) and changes it only between packets. It sits directly in front of the uart_transmitter write port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DEFAULT_THRESHOLD, 6'd48, tx_buffer_full_threshold value after reset
DEFAULT_BAUD, 2'd0, tx_baudrate_select value after reset
TIMEOUT_CYCLES, 1024, mid-packet stall limit (used only with optional feature)

Ports:
clock  in  1  clock
reset  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  byte is last of packet
req_ready  out  NUM_REQ  byte accepted when valid&&ready
cfg_valid  in  1  configuration update request
cfg_threshold  in  6  new buffer_full_threshold
cfg_baudrate  in  2  new baudrate_select
cfg_ready  out  1  configuration accepted when cfg_valid&&cfg_ready
tx_buffer_full  in  1  from transmitter
tx_write_enable  out  1  to transmitter, registered
tx_data  out  8  to transmitter, registered
tx_buffer_full_threshold  out  6  to transmitter, registered
tx_baudrate_select  out  2  to transmitter, registered
grant  out  NUM_REQ  one-hot current owner, 0 in IDLE
busy  out  1  high while in SEND
timeout  out  1  one-cycle pulse on forced release (tied 0 without feature)

Behaviour:
- Reset values (async, on reset=0): state IDLE, rr pointer 0, grant 0, busy 0, tx_write_enable 0, tx_data 0, tx_buffer_full_threshold DEFAULT_THRESHOLD, tx_baudrate_select DEFAULT_BAUD, timeout 0. req_ready and cfg_ready are 0 while reset is low.
- States: IDLE, SEND.
- IDLE:
  - cfg_ready=1 (combinational).
  - If cfg_valid: latch cfg_* into tx_* registers next edge. Arbitration is suppressed that cycle (config wins a tie).
  - Otherwise, if any req_valid: pick the first valid index at or after the pointer, wrapping modulo NUM_REQ. Next edge: grant=onehot(pick), state SEND.
  - req_ready=0.
- SEND:
  - cfg_ready=0.
  - req_ready[g] = !tx_buffer_full for the granted g; all other req_ready bits are 0.
  - On a beat (req_valid[g]&&req_ready[g]): next edge tx_write_enable=1, tx_data=req_data[g]. Latency is 1 cycle.
  - With no beat, tx_write_enable=0 and tx_data holds its value.
  - Beat with req_last[g]: next edge state IDLE, grant 0, pointer=(g+1) mod NUM_REQ. At least one IDLE cycle separates packets.
  - req_valid dropping mid-packet does not release the grant.
- Flow control: one write may already be registered when buffer_full rises, so the integrator must set threshold ≤ transmitter depth − 2.
- Config changes never occur while busy=1.
- Reset mid-packet: immediate return to reset values; the partial packet is discarded. The requester must resend.

Optional Feature:
Macro UART_TX_ARB_TIMEOUT_EN.
- With it: a stall counter runs in SEND. It clears on every beat and increments on cycles with !req_valid[g]; cycles where tx_buffer_full stalls do not count. When it reaches TIMEOUT_CYCLES, the next edge forces IDLE, grant=0, pointer=g+1, and timeout=1 for one cycle.
- Without it: no counter, timeout tied 0, and a stalled owner holds the transmitter indefinitely.

Decomposition:
- Package uart_tx_arbiter_pkg holds:
  - state enum {IDLE, SEND}
  - BYTE_W=8, THRESH_W=6, BAUD_W=2
  - reset-default constants
- Sub-module rr_picker: combinational. Inputs are request vector and pointer; outputs are one-hot pick and found flag. It is reusable and tested standalone.

Test Plan:
- Single requester 1 sends 3 bytes 0xA1,0xA2,0xA3(last) with tx_buffer_full=0 → grant=4'b0010 one cycle after valid; tx_write_enable high 3 consecutive cycles with 0xA1..0xA3 at 1-cycle latency; IDLE afterwards, pointer=2.
- All 4 requesters continuously valid, 2-byte packets → grants in order 0,1,2,3,0; no interleaving of bytes within a packet; one IDLE cycle between packets.
- tx_buffer_full=1 for 5 cycles mid-packet → req_ready[g]=0 and tx_write_enable=0 for those 5 cycles; no byte lost or duplicated; resumes with the next byte.
- cfg_valid with threshold=20, baud=2 while busy → cfg_ready=0 until the packet's last byte; applied in the first IDLE cycle. cfg_valid and req_valid together in IDLE → config applied first, grant one cycle later.
- Assert reset mid-packet after byte 2 of 4 → all outputs return to reset values asynchronously; after release, the next grant starts from requester 0.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner drops valid mid-packet → timeout pulse after 16 cycles, grant moves to the next valid requester. Holding tx_buffer_full=1 for 40 cycles produces no timeout.
